// File: rtl/vga_pkg.sv
// Shared constants, pixel type, FSM states and frame address helper for the VGA frame buffer.
// Pure declarations: no latency and no flow control of its own.
package vga_pkg;

    localparam int FB_W        = 160;
    localparam int FB_H        = 120;
    localparam int SCALE_SHIFT = 2;
    localparam int SCR_W       = 640;
    localparam int SCR_H       = 480;
    localparam int FB_DEPTH    = 19200;
    localparam int ADDR_W      = 15;

    typedef struct packed {
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] r;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    // y*160 + x as two shifts and adds, so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Frame store: one synchronous write port, one asynchronous read port (distributed RAM).
// Read data is combinational from raddr; writes land at the clock edge; never stalls.
module fb_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pixel_t        wdata,
    input  logic [AW-1:0] raddr,
    output pixel_t        rdata
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vga_framebuffer.sv
// 160x120x12 frame buffer with 4x upscaled combinational read, single-pixel writes and rectangle fills.
// Read has zero latency; cmd_ready drops while clearing after reset or while a fill walks its rectangle.
module vga_framebuffer #(
    parameter int          FB_W        = vga_pkg::FB_W,
    parameter int          FB_H        = vga_pkg::FB_H,
    parameter int          SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
    parameter logic [11:0] RESET_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic        read_pixel,
    output logic [11:0] pixel_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [7:0]  cmd_x0,
    input  logic [7:0]  cmd_x1,
    input  logic [6:0]  cmd_y0,
    input  logic [6:0]  cmd_y1,
    input  logic [11:0] cmd_color,
    output logic        busy
);

    import vga_pkg::*;

    localparam logic [7:0]        X_MAX    = 8'(FB_W - 1);
    localparam logic [6:0]        Y_MAX    = 7'(FB_H - 1);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(FB_W * FB_H - 1);
    localparam logic [9:0]        COL_LIM  = 10'(SCR_W);
    localparam logic [8:0]        ROW_LIM  = 9'(SCR_H);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_addr;
    logic [7:0]          cx, xl, xh;
    logic [6:0]          cy, yh;
    pixel_t              fill_color;

    logic [7:0]          nx_lo, nx_hi;
    logic [6:0]          ny_lo, ny_hi;

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    pixel_t              wdata;

    logic                rd_ok;
    logic [9:0]          col_s;
    logic [8:0]          row_s;
    logic [ADDR_W-1:0]   raddr;
    pixel_t              rdata;

    // Sort corners, then clip every coordinate into the stored frame
    always_comb begin
        nx_lo = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
        nx_hi = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
        ny_lo = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
        ny_hi = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
        if (nx_lo > X_MAX) nx_lo = X_MAX;
        if (nx_hi > X_MAX) nx_hi = X_MAX;
        if (ny_lo > Y_MAX) ny_lo = Y_MAX;
        if (ny_hi > Y_MAX) ny_hi = Y_MAX;
    end

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        case (state)
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = clr_addr;
                wdata = RESET_COLOR;
                if (clr_addr == LAST_ADR) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op) begin
                        state_nxt = ST_FILL;
                    end else if (cmd_x0 <= X_MAX && cmd_y0 <= Y_MAX) begin
                        we    = 1'b1;
                        waddr = fb_addr(cmd_x0, cmd_y0);
                        wdata = cmd_color;
                    end
                end
            end
            ST_FILL: begin
                we    = 1'b1;
                waddr = fb_addr(cx, cy);
                wdata = fill_color;
                if (cx == xh && cy == yh) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr <= '0;
        end else begin
            if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
            if (state == ST_IDLE && cmd_valid && cmd_op) begin
                xl         <= nx_lo;
                xh         <= nx_hi;
                yh         <= ny_hi;
                cx         <= nx_lo;
                cy         <= ny_lo;
                fill_color <= cmd_color;
            end
            if (state == ST_FILL) begin
                if (cx == xh) begin
                    cx <= xl;
                    cy <= cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Out-of-screen reads park the RAM address at 0 so it never indexes past the array
    assign col_s = col >> SCALE_SHIFT;
    assign row_s = row >> SCALE_SHIFT;
    assign rd_ok = !read_pixel && (col < COL_LIM) && (row < ROW_LIM);
    assign raddr = rd_ok ? fb_addr(col_s[7:0], row_s[6:0]) : '0;
    assign pixel_data = rd_ok ? rdata : 12'h000;

    fb_ram #(
        .DEPTH (FB_W * FB_H),
        .AW    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we && !rst),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: doc/vga_framebuffer.md
# vga_framebuffer

Pixel source that feeds the VGA timing stage. It holds a 160×120×12-bit frame, stored row-major, and answers the VGA stage's `row`/`col`/`read_pixel` request combinationally with `pixel_data`, upscaling each stored pixel to 4×4 screen pixels. A command port lets the rest of the design write single pixels or fill rectangles, one pixel per cycle. After every reset the block clears the frame to `RESET_COLOR`.

## Interface
- `FB_W`, 160: stored frame width in pixels.
- `FB_H`, 120: stored frame height in pixels.
- `SCALE_SHIFT`, 2: screen-to-frame scale as log2; the scale is 4.
- `RESET_COLOR`, 12'h000: fill value written during the post-reset clear.

Ports:
- `clk`  in  1  pixel clock, the same clock the VGA stage uses.
- `rst`  in  1  **reset is synchronous and active-high; one clock**.
- `row`  in  9  screen row from the VGA stage, 0..479 while visible.
- `col`  in  10  screen column from the VGA stage, 0..639 while visible.
- `read_pixel`  in  1  read request, active-low.
- `pixel_data`  out  12  pixel value, packed as {B[3:0], G[3:0], R[3:0]}.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  the block can accept a command.
- `cmd_op`  in  1  0 = single pixel write at (`cmd_x0`, `cmd_y0`); 1 = rectangle fill.
- `cmd_x0`, `cmd_x1`  in  8  frame x coordinates.
- `cmd_y0`, `cmd_y1`  in  7  frame y coordinates.
- `cmd_color`  in  12  color to write.
- `busy`  out  1  high in the CLEAR and FILL states.

## Operation
- Storage: `FB_W*FB_H` = 19200 words of 12 bits, with asynchronous read and synchronous write.
- Address is `y*160 + x`, 15 bits, computed as `(y<<7)+(y<<5)+x`. No multiplier.

Read path (purely combinational):
- x = `col >> 2`, y = `row >> 2`.
- `pixel_data` = mem[addr] only when `read_pixel`=0, `col`<640 and `row`<480. Otherwise `pixel_data` = 0.

FSM states: CLEAR, IDLE, FILL.
- **CLEAR** (entered on reset):
  - Walks the address counter from 0 to 19199, writing `RESET_COLOR` each cycle.
  - Moves to IDLE after the write to address 19199.
- **IDLE**:
  - `cmd_ready`=1.
  - On an accepted op-0 command, writes the pixel at that same edge and stays in IDLE.
  - On an accepted op-1 command, latches the rectangle and color and moves to FILL.
- **FILL**:
  - Writes one pixel per cycle in row-major order: x varies fastest, from xl to xh, then y increments.
  - Moves to IDLE after the write at (xh, yh).

Rectangle normalization at acceptance:
- xl = min(x0, x1), xh = max(x0, x1); yl and yh likewise.
- xh is clipped to 159 and yh to 119. xl and yl are clipped too.
- The fill is inclusive, so a fill takes (xh−xl+1)·(yh−yl+1) cycles.

Single writes out of range:
- An op-0 command with x>159 or y>119 is accepted and discarded, with no write.

Outputs:
- `cmd_ready` = (state==IDLE), decoded directly from the state register.
- `busy` = (state!=IDLE).

## Timing
- **Reset values:** state=CLEAR, `cmd_ready`=0, `busy`=1. `pixel_data` follows the read path, which is combinational.
- **Clear duration:** `rst` is high at edge 0. CLEAR writes on edges 1..19200. `cmd_ready` is 1 after edge 19200.
- **Reset mid-operation:** `rst` at any point aborts CLEAR or FILL and restarts CLEAR from address 0. A partly written rectangle is then overwritten by the clear.
- **Handshake:** a command is accepted at a rising edge where `cmd_valid` and `cmd_ready` are both 1. Command fields are sampled only at that edge.
- **Single writes:** accepted back to back at one per cycle.
- **Fill timing:** for a fill accepted at edge k with N pixels, writes occur at edges k+1..k+N. `cmd_ready` rises after edge k+N, so the next command is accepted at edge k+N+1 at the earliest.
- **Read-after-write:** a value written at edge k is visible on `pixel_data` after edge k. Tearing during live scan-out is permitted.
- **Read latency:** `pixel_data` has zero-cycle latency from `row`/`col`. The VGA stage registers `row`/`col` and samples `pixel_data` at the following edge.

## Structure
- Shared package `vga_pkg`:
  - constants FB_W, FB_H, SCALE_SHIFT, SCR_W=640, SCR_H=480, FB_DEPTH=19200;
  - the pixel type (12-bit {B, G, R});
  - the FSM state enum.
- One sub-module, `fb_ram`: 19200×12 memory with one synchronous write port and one asynchronous read port (distributed RAM).
- The top level holds the FSM, the x/y walk counters, the address arithmetic and the read mapping.

## Test plan
1. **Reset and clear.** Assert `rst` for one cycle with `RESET_COLOR`=12'h00F.
   - `cmd_ready` is 0 for exactly 19200 cycles after reset, then 1.
   - Reading (row=479, col=639) returns 12'h00F.
2. **Single write and upscaling.** Write op 0 at (10, 5) with color 12'hABC.
   - rows 20..23 × cols 40..43 read 12'hABC.
   - (row=24, col=40) reads 12'h00F.
3. **Swapped rectangle.** Fill op 1 with x0=3, x1=1, y0=2, y1=2, color 12'h0F0.
   - `busy` stays high for exactly 3 cycles.
   - (1,2), (2,2) and (3,2) read 12'h0F0; (0,2) is unchanged.
4. **Clipping and discard.** Fill with x 150..200 and y 118..127.
   - Takes 10×2 = 20 cycles; (159, 119) is written.
   - A following op-0 write at x=170 leaves the memory unchanged.
5. **Reset mid-fill.** Fill the whole frame (19200 cycles) and assert `rst` after 100 cycles.
   - CLEAR restarts and all pixels end as `RESET_COLOR`.
6. **Read gating.** With `read_pixel`=1, or with col=700, or with row=500:
   - `pixel_data` = 0 regardless of memory contents.
